bus_arbiter_rr: RTL and testbench
=================================

Name: bus_arbiter_rr

Overview:
- Parametrised round-robin bus arbiter for NUM_MASTERS requesters (core instruction/data arbitration sub-modules) sharing one memory bus.
- Implements the RQ/GRANT handshake the arbitration sub-modules expect:
  - grant only while the bus memory ready signal is low;
  - hold the grant while the owner keeps RQ high;
  - wait for memory ready low before re-arbitrating.
- Adds fair rotation across masters and an optional hold-timeout that forcibly revokes a grant.

Parameters:
- NUM_MASTERS, 4, number of requesters (2..16).
- MAX_HOLD, 0, maximum consecutive GRANT-state cycles per ownership. 0 disables the timeout. Legal range 0..65535.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- rq  input  NUM_MASTERS  per-master bus request; bit i from master i.
- bus_mem_ready  input  1  ready signal from bus memory; high = data valid / transfer still completing.
- grant  output  NUM_MASTERS  one-hot (or zero) registered grant.
- grant_id  output  clog2(NUM_MASTERS)  index of the current or last owner.
- bus_busy  output  1  high in any state other than IDLE.
- timeout_pulse  output  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-grant):
  - grant=0, grant_id=0, bus_busy=0, timeout_pulse=0, state=IDLE, hold_cnt=0.
  - Round-robin pointer last_owner = NUM_MASTERS-1, so master 0 has first priority after reset.
- All outputs are registered. grant is never more than one-hot.
- States: IDLE, GRANT, WAIT_MEM_LOW.
- IDLE:
  - At an edge where |rq=1 and bus_mem_ready=0: winner = first i with rq[i]=1, searching last_owner+1, last_owner+2, ... modulo NUM_MASTERS.
  - On that edge: grant[winner]<=1, grant_id<=winner, last_owner<=winner, hold_cnt<=0, state<=GRANT.
  - Latency is one edge: grant is visible in the cycle after the edge that samples the request.
  - If bus_mem_ready=1, no grant is issued; the arbiter stays in IDLE.
- GRANT:
  - Requests from non-owners are ignored.
  - Each edge with rq[owner]=1 increments hold_cnt (16-bit, saturating).
  - If rq[owner]=0 at an edge: grant<=0, state<=WAIT_MEM_LOW.
  - Else, if MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1: grant<=0, timeout_pulse<=1 for exactly one cycle, state<=WAIT_MEM_LOW.
  - A release and a timeout on the same edge count as a normal release; no timeout_pulse.
- WAIT_MEM_LOW:
  - grant=0.
  - At an edge with bus_mem_ready=0: state<=IDLE. Otherwise remain.
- Minimum gap between successive grants is two cycles: one in WAIT_MEM_LOW, one in IDLE.
- A master revoked by timeout that keeps rq high is re-eligible, but the pointer has advanced past it, so other pending masters are served first.
- grant_id holds its value after release until the next grant.
- bus_busy = (state != IDLE), registered with the state.

Test Plan:
- Single request: NUM_MASTERS=4, reset released, rq=4'b0100, bus_mem_ready=0 → grant=4'b0100 and grant_id=2 one cycle later. rq dropped → grant=0 next cycle. bus_busy falls one cycle after bus_mem_ready=0 is seen.
- Round-robin fairness: rq=4'b1111 held; each owner drops rq for one cycle after 3 cycles of grant → grant order 0,1,2,3,0; never two grant bits high simultaneously.
- Memory ready gating: rq=4'b0001 with bus_mem_ready=1 for 5 cycles → grant stays 0. bus_mem_ready falls → grant=4'b0001 one cycle later. After release with bus_mem_ready=1, the arbiter stays in WAIT_MEM_LOW (grant 0, bus_busy 1) until ready falls.
- Timeout: MAX_HOLD=4, master 1 holds rq high, master 3 also requesting → grant[1] high for exactly 4 cycles, then timeout_pulse=1 for one cycle; next grant goes to master 3, not 1.
- Simultaneous release and timeout: MAX_HOLD=4, owner drops rq on the 4th grant cycle → grant drops, timeout_pulse stays 0.
- Reset mid-operation: assert reset while grant=4'b0010 (between clock edges) → grant=0 and bus_busy=0 immediately. After release with rq=4'b0011 → master 0 is granted first.

Source files
------------

// File: rtl/bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_rr
// Brief    : Round-robin arbiter for NUM_MASTERS requesters sharing one
//            memory bus. It uses an RQ/GRANT handshake gated by the memory
//            ready signal and has an optional hold timeout that revokes
//            a grant.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter_rr #(
  parameter int NUM_MASTERS = 4,
  parameter int MAX_HOLD    = 0
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [NUM_MASTERS-1:0]         rq_i,
  input  logic                           bus_mem_ready_i,
  output logic [NUM_MASTERS-1:0]         grant_o,
  output logic [$clog2(NUM_MASTERS)-1:0] grant_id_o,
  output logic                           bus_busy_o,
  output logic                           timeout_pulse_o
);

  localparam int                IDW          = $clog2(NUM_MASTERS);
  localparam logic [IDW:0]      C_NUM        = (IDW+1)'(NUM_MASTERS);
  localparam logic [IDW-1:0]    C_LAST_INIT  = IDW'(NUM_MASTERS-1);
  localparam logic [15:0]       C_HOLD_LAST  = 16'(MAX_HOLD-1);
  localparam logic [15:0]       C_HOLD_SAT   = 16'hFFFF;
  localparam bit                C_TIMEOUT_EN = (MAX_HOLD != 0);
  localparam logic [NUM_MASTERS-1:0] C_ONE   = NUM_MASTERS'(1);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_GRANT        = 2'd1,
    ST_WAIT_MEM_LOW = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_MASTERS-1:0]  grant_q, grant_d;
  logic [IDW-1:0]          grant_id_q, grant_id_d;
  logic [IDW-1:0]          last_q, last_d;
  logic [15:0]             hold_q, hold_d;
  logic                    timeout_q, timeout_d;
  logic                    busy_q, busy_d;

  // Request vector repeated twice so the rotated search never needs a modulo.
  logic [2*NUM_MASTERS-1:0] w_rq_dbl;
  logic [IDW:0]             w_pos;
  logic [IDW:0]             w_wrap;
  logic                     w_found;
  logic [IDW-1:0]           w_win;
  logic                     w_own_rq;

  assign w_rq_dbl = {rq_i, rq_i};
  assign w_own_rq = rq_i[grant_id_q];

  // Find the first requester after the last owner, wrapping around once.
  always_comb begin
    w_pos   = '0;
    w_wrap  = '0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      w_pos = {1'b0, last_q} + (IDW+1)'(k);
      if (!w_found && w_rq_dbl[w_pos]) begin
        w_found = 1'b1;
        w_wrap  = (w_pos >= C_NUM) ? (w_pos - C_NUM) : w_pos;
        w_win   = w_wrap[IDW-1:0];
      end
    end
  end

  // Next-state and output decode for the IDLE / GRANT / WAIT_MEM_LOW handshake.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    last_d     = last_q;
    hold_d     = hold_q;
    timeout_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (w_found && !bus_mem_ready_i) begin
          grant_d    = C_ONE << w_win;
          grant_id_d = w_win;
          last_d     = w_win;
          hold_d     = '0;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (w_own_rq && (hold_q != C_HOLD_SAT)) begin
          hold_d = hold_q + 16'd1;
        end
        // A release on the same edge as the timeout wins: no pulse.
        if (!w_own_rq) begin
          grant_d = '0;
          state_d = ST_WAIT_MEM_LOW;
        end else if (C_TIMEOUT_EN && (hold_q == C_HOLD_LAST)) begin
          grant_d   = '0;
          timeout_d = 1'b1;
          state_d   = ST_WAIT_MEM_LOW;
        end
      end
      ST_WAIT_MEM_LOW: begin
        grant_d = '0;
        if (!bus_mem_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset takes effect immediately.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      last_q     <= C_LAST_INIT;
      hold_q     <= '0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      last_q     <= last_d;
      hold_q     <= hold_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
    end
  end

  assign grant_o         = grant_q;
  assign grant_id_o      = grant_id_q;
  assign bus_busy_o      = busy_q;
  assign timeout_pulse_o = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter_rr
// Brief    : Self-checking bench for bus_arbiter_rr. It runs directed
//            scenarios and then randomized traffic against a behavioural
//            ownership model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter_rr;

  localparam int N  = 4;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] rq;
  logic         rdy;
  logic [N-1:0] grant;
  logic [1:0]   gid;
  logic         busy;
  logic         tp;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: which master owns the bus (-1 = nobody), whether the bus is
  // released but waiting for memory ready low, and fairness bookkeeping.
  int m_owner;
  int m_last;
  int m_cycles;
  int m_gid;
  bit m_wait;
  bit m_tp;

  always #5 clk = ~clk;

  bus_arbiter_rr #(.NUM_MASTERS(N), .MAX_HOLD(MH)) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .rq_i            (rq),
    .bus_mem_ready_i (rdy),
    .grant_o         (grant),
    .grant_id_o      (gid),
    .bus_busy_o      (busy),
    .timeout_pulse_o (tp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_last   = N - 1;
    m_cycles = 0;
    m_gid    = 0;
    m_wait   = 1'b0;
    m_tp     = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic m);
    bit found;
    int cand;
    m_tp = 1'b0;
    if (m_owner >= 0) begin
      m_cycles++;
      if (!r[m_owner]) begin
        m_owner = -1;
        m_wait  = 1'b1;
      end else if (MH != 0 && m_cycles == MH) begin
        m_owner = -1;
        m_wait  = 1'b1;
        m_tp    = 1'b1;
      end
    end else if (m_wait) begin
      if (!m) m_wait = 1'b0;
    end else if (r != '0 && !m) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        cand = (m_last + k) % N;
        if (!found && r[cand]) begin
          found   = 1'b1;
          m_owner = cand;
        end
      end
      m_last   = m_owner;
      m_gid    = m_owner;
      m_cycles = 0;
    end
  endtask

  task automatic compare_model();
    logic [31:0] eg;
    logic [31:0] eb;
    eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    eb = (m_owner >= 0 || m_wait) ? 32'd1 : 32'd0;
    check("grant",         32'(grant), eg);
    check("grant_id",      32'(gid),   32'(m_gid));
    check("bus_busy",      32'(busy),  eb);
    check("timeout_pulse", 32'(tp),    32'(m_tp));
    check("onehot",        32'($countones(grant) <= 1), 32'd1);
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic m);
    rq  = r;
    rdy = m;
    @(posedge clk);
    model_step(r, m);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    compare_model();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : main
    logic [N-1:0] order[$];
    logic [N-1:0] rqv;
    logic [N-1:0] prev;
    logic [N-1:0] r;
    logic [N-1:0] nxt;
    int           run;
    int           g1;
    int           tpc;
    bit           seen_tp;

    reset = 1'b1;
    rq    = '0;
    rdy   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant",    32'(grant), 32'd0);
    check("rst_grant_id", 32'(gid),   32'd0);
    check("rst_busy",     32'(busy),  32'd0);
    check("rst_timeout",  32'(tp),    32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single request, release, then memory-ready low ends the busy period.
    cycle(4'b0100, 1'b0);
    check("single_grant",    32'(grant), 32'h4);
    check("single_grant_id", 32'(gid),   32'd2);
    cycle(4'b0100, 1'b0);
    cycle(4'b0000, 1'b0);
    check("single_release", 32'(grant), 32'd0);
    check("single_busy_w",  32'(busy),  32'd1);
    cycle(4'b0000, 1'b0);
    check("single_busy_off", 32'(busy), 32'd0);
    check("single_id_held",  32'(gid),  32'd2);

    // Fairness: all request; each owner drops rq after 3 grant cycles.
    do_reset();
    rqv  = 4'hF;
    prev = '0;
    run  = 0;
    for (int c = 0; c < 40; c++) begin
      cycle(rqv, 1'b0);
      if (grant != '0 && grant != prev) order.push_back(grant);
      run  = (grant != '0 && grant == prev) ? run + 1 : ((grant != '0) ? 1 : 0);
      prev = grant;
      rqv  = (run == 3) ? (4'hF & ~grant) : 4'hF;
    end
    for (int i = 0; i < 5; i++) begin
      check("rr_order", (i < order.size()) ? 32'(order[i]) : 32'd0, 32'd1 << (i % 4));
    end

    // Memory ready gating on both grant and the return to IDLE.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      cycle(4'b0001, 1'b1);
      check("gate_no_grant", 32'(grant), 32'd0);
    end
    cycle(4'b0001, 1'b0);
    check("gate_grant", 32'(grant), 32'h1);
    cycle(4'b0000, 1'b1);
    for (int c = 0; c < 3; c++) begin
      cycle(4'b0000, 1'b1);
      check("gate_wait_grant", 32'(grant), 32'd0);
      check("gate_wait_busy",  32'(busy),  32'd1);
    end
    cycle(4'b0000, 1'b0);
    check("gate_idle_busy", 32'(busy), 32'd0);

    // Timeout: master 1 holds, master 3 waiting; master 3 is served next.
    do_reset();
    g1      = 0;
    tpc     = 0;
    nxt     = '0;
    seen_tp = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cycle(4'b1010, 1'b0);
      if (grant == 4'b0010) g1++;
      if (tp) begin
        tpc++;
        seen_tp = 1'b1;
      end
      if (seen_tp && nxt == '0 && grant != '0) nxt = grant;
    end
    check("to_hold_cycles", 32'(g1),  32'd4);
    check("to_pulse_count", 32'(tpc), 32'd1);
    check("to_next_owner",  32'(nxt), 32'h8);

    // Release on the same edge as the timeout counts as a normal release.
    do_reset();
    for (int c = 0; c < 4; c++) cycle(4'b0010, 1'b0);
    cycle(4'b0000, 1'b0);
    check("simul_grant",   32'(grant), 32'd0);
    check("simul_timeout", 32'(tp),    32'd0);

    // Asynchronous reset while master 1 owns the bus.
    do_reset();
    cycle(4'b0010, 1'b0);
    cycle(4'b0010, 1'b0);
    check("mid_pre_grant", 32'(grant), 32'h2);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_busy",  32'(busy),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    cycle(4'b0011, 1'b0);
    check("mid_first_owner", 32'(grant), 32'h1);

    // Randomized traffic with occasional asynchronous resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      r = N'($urandom) | N'($urandom);
      cycle(r, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
